// File: rtl/mod_updown_counter_pkg.sv
// Shared types for the up/down event counter: the per-edge action the
// counter takes, and the priority decode that picks it.
package mod_updown_counter_pkg;

  // What the counter does at the next rising edge.
  typedef enum logic [2:0] {
    ACT_HOLD         = 3'd0,  // no clear, no load, no tick
    ACT_CLEAR        = 3'd1,  // synchronous clear (count, flag, prescaler)
    ACT_LOAD         = 3'd2,  // parallel load, clamped to the modulus
    ACT_INC          = 3'd3,  // ordinary up step
    ACT_DEC          = 3'd4,  // ordinary down step
    ACT_WRAP_TO_ZERO = 3'd5,  // up step from MAX_COUNT in wrap mode
    ACT_WRAP_TO_MAX  = 3'd6,  // down step from 0 in wrap mode
    ACT_SATURATE     = 3'd7   // step at an end in saturate mode: hold
  } action_e;

  // Priority decode: clear > load > step > hold. at_end means the count
  // sits on the end that the current direction is heading towards.
  function automatic action_e select_action(
    input logic clear,
    input logic load,
    input logic tick,
    input logic up,
    input logic at_end,
    input logic saturate
  );
    action_e act;
    act = ACT_HOLD;
    if (clear) begin
      act = ACT_CLEAR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (tick) begin
      if (!at_end) begin
        act = up ? ACT_INC : ACT_DEC;
      end else if (saturate) begin
        act = ACT_SATURATE;
      end else begin
        act = up ? ACT_WRAP_TO_ZERO : ACT_WRAP_TO_MAX;
      end
    end
    return act;
  endfunction

  // Actions that hit an end of the range and therefore set the sticky flag.
  function automatic logic action_overflows(input action_e act);
    return (act == ACT_WRAP_TO_ZERO) || (act == ACT_WRAP_TO_MAX) ||
           (act == ACT_SATURATE);
  endfunction

endpackage

// File: rtl/mod_updown_counter_prescaler.sv
// Enable prescaler: produces one tick every PRESCALE enabled cycles.
// restart zeroes the partial count and suppresses the tick that cycle.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE must be >= 1");
  end

  if (PRESCALE <= 1) begin : g_passthru
    // Every enabled cycle is a step; no state is needed.
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign tick = enable & ~restart;
  end else begin : g_count
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the enabled cycle that completes a full prescale period.
    assign tick = enable & ~restart & (cnt_q == LAST);

    // Next prescale count: restart wins, then advance only while enabled.
    always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
        cnt_d = '0;
      end else if (enable) begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
      end
    end

    // Prescale count register; reset discards any partial period.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// General-purpose up/down event counter with programmable modulus,
// wrap or saturate behaviour, enable prescaler, synchronous clear/load,
// combinational terminal count and a sticky overflow flag.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
  parameter bit          SATURATE  = 1'b0,
  parameter int          PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             overflow
);

  // Parameter legality is checked while the design elaborates.
  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..31");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH - 1)) begin : g_bad_max
    $error("mod_updown_counter: MAX_COUNT must be in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             restart;
  logic             at_end;
  logic [WIDTH-1:0] load_clamped;
  action_e          action;

  // Clear and load both restart the prescale period.
  assign restart = clear | load;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .restart (restart),
    .tick    (tick)
  );

  // Loads above the modulus are clamped so the count never leaves 0..MAX.
  assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

  // The count sits on the end it is heading towards in this direction.
  always_comb begin
    at_end = up_down ? (count_q == MAX_V) : (count_q == '0);
  end

  // Decide this cycle's action with clear > load > step > hold priority.
  always_comb begin
    action = select_action(clear, load, tick, up_down, at_end, SATURATE);
  end

  // Next count and sticky flag from the selected action.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q | action_overflows(action);
    case (action)
      ACT_CLEAR: begin
        count_d = '0;
        ovf_d   = 1'b0;
      end
      ACT_LOAD:         count_d = load_clamped;
      ACT_INC:          count_d = count_q + ONE;
      ACT_DEC:          count_d = count_q - ONE;
      ACT_WRAP_TO_ZERO: count_d = '0;
      ACT_WRAP_TO_MAX:  count_d = MAX_V;
      ACT_SATURATE:     count_d = count_q;
      default:          count_d = count_q;
    endcase
  end

  // Terminal count: a step is due this cycle and it would cross the end.
  // clear/load already gate tick, the explicit terms keep intent visible.
  always_comb begin
    terminal_count = tick & at_end & ~clear & ~load;
  end

  // Count and sticky-flag registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter_out = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter. Three instances share one set of
// inputs: A = defaults (mod 16, wrap), B = MAX_COUNT 9 saturating,
// C = mod 16 wrap with PRESCALE 3. A behavioural model per instance pushes
// the expected post-edge {count, overflow} into a queue when inputs are
// driven; the entries are popped and compared after the edge.
module tb_mod_updown_counter;

  localparam int W = 5;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;

  logic [W-1:0] exp_q[$];

  int checks = 0;
  int passed = 0;

  // model configuration and state per instance
  int max_c[3] = '{15, 9, 15};
  int sat_c[3] = '{0, 1, 0};
  int pre_c[3] = '{1, 1, 3};
  int m_cnt[3];
  int m_ovf[3];
  int m_pre[3];

  mod_updown_counter #(.WIDTH(4)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .counter_out(cnt_a), .terminal_count(tc_a), .overflow(ovf_a)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .counter_out(cnt_b), .terminal_count(tc_b), .overflow(ovf_b)
  );

  mod_updown_counter #(.WIDTH(4), .PRESCALE(3)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .counter_out(cnt_c), .terminal_count(tc_c), .overflow(ovf_c)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  function automatic logic [W-1:0] dut_state(input int i);
    case (i)
      0:       return {cnt_a, ovf_a};
      1:       return {cnt_b, ovf_b};
      default: return {cnt_c, ovf_c};
    endcase
  endfunction

  function automatic logic dut_tc(input int i);
    case (i)
      0:       return tc_a;
      1:       return tc_b;
      default: return tc_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
      m_pre[i] = 0;
    end
  endtask

  // Driver: called at a falling edge. Drives inputs, checks terminal_count
  // against the model, queues the expected post-edge state, then after the
  // rising edge pops and compares on the following falling edge.
  task automatic step(input logic en, input logic ud, input logic clr,
                      input logic ld, input logic [3:0] lv);
    bit tick;
    bit at_end;
    logic [W-1:0] e;
    enable = en; up_down = ud; clear = clr; load = ld; load_value = lv;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick   = 1'b0;
      at_end = ud ? (m_cnt[i] == max_c[i]) : (m_cnt[i] == 0);
      if (clr) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (int'(lv) > max_c[i]) ? max_c[i] : int'(lv);
        m_pre[i] = 0;
      end else if (en) begin
        if (m_pre[i] == pre_c[i] - 1) begin
          tick = 1'b1; m_pre[i] = 0;
        end else begin
          m_pre[i]++;
        end
      end
      chk($sformatf("tc[%0d]", i), 32'(dut_tc(i)), 32'(tick && at_end));
      if (tick) begin
        if (at_end) begin
          m_ovf[i] = 1;
          if (sat_c[i] == 0) m_cnt[i] = ud ? 0 : max_c[i];
        end else begin
          m_cnt[i] = ud ? m_cnt[i] + 1 : m_cnt[i] - 1;
        end
      end
      exp_q.push_back({4'(m_cnt[i]), 1'(m_ovf[i])});
    end
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("count[%0d]", i), 32'(dut_state(i) >> 1), 32'(e >> 1));
      chk($sformatf("ovf[%0d]", i), 32'(dut_state(i) & 5'd1), 32'(e & 5'd1));
    end
  endtask

  // Asserts reset between edges and checks the outputs drop immediately.
  task automatic async_reset();
    enable = 1'b0; clear = 1'b0; load = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_count[%0d]", i), 32'(dut_state(i) >> 1), 32'd0);
      chk($sformatf("rst_ovf[%0d]", i), 32'(dut_state(i) & 5'd1), 32'd0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; up_down = 1'b1;
    clear = 1'b0; load = 1'b0; load_value = '0;
    model_reset();
    #3;
    chk("init_count_a", 32'(cnt_a), 32'd0);
    chk("init_ovf_a", 32'(ovf_a), 32'd0);
    chk("init_count_c", 32'(cnt_c), 32'd0);
    @(negedge clock);  // t=10
    reset = 1'b1;

    // basic up count with wrap
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0, 4'd0);
    chk("basic_count_a", 32'(cnt_a), 32'd4);
    chk("basic_ovf_a", 32'(ovf_a), 32'd1);

    // modulo 10 saturate: up past 9, then down past 0
    async_reset();
    for (int k = 0; k < 12; k++) step(1, 1, 0, 0, 4'd0);
    chk("sat_hi_b", 32'(cnt_b), 32'd9);
    chk("sat_ovf_b", 32'(ovf_b), 32'd1);
    for (int k = 0; k < 11; k++) step(1, 0, 0, 0, 4'd0);
    chk("sat_lo_b", 32'(cnt_b), 32'd0);

    // load clamp, load beats step, then a normal step
    step(0, 1, 0, 1, 4'd12);
    chk("load_clamp_b", 32'(cnt_b), 32'd9);
    chk("load_noclamp_a", 32'(cnt_a), 32'd12);
    step(1, 1, 0, 1, 4'd5);
    chk("load_nostep_b", 32'(cnt_b), 32'd5);
    step(1, 1, 0, 0, 4'd0);
    chk("after_load_b", 32'(cnt_b), 32'd6);
    chk("after_load_c", 32'(cnt_c), 32'd5);

    // prescaler: steady, enable gap, load mid-prescale
    async_reset();
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 4'd0);
    chk("pre_steady_c", 32'(cnt_c), 32'd1);
    step(0, 1, 0, 0, 4'd0);
    step(0, 1, 0, 0, 4'd0);
    chk("pre_gap_hold_c", 32'(cnt_c), 32'd1);
    step(1, 1, 0, 0, 4'd0);
    chk("pre_gap_step_c", 32'(cnt_c), 32'd2);
    step(1, 1, 0, 0, 4'd0);
    step(1, 1, 0, 1, 4'd3);
    step(1, 1, 0, 0, 4'd0);
    step(1, 1, 0, 0, 4'd0);
    chk("pre_load_wait_c", 32'(cnt_c), 32'd3);
    step(1, 1, 0, 0, 4'd0);
    chk("pre_load_step_c", 32'(cnt_c), 32'd4);

    // priority: down wrap sets flag, then clear+load+enable together
    async_reset();
    step(1, 0, 0, 0, 4'd0);
    chk("down_wrap_a", 32'(cnt_a), 32'd15);
    chk("down_wrap_ovf_a", 32'(ovf_a), 32'd1);
    step(1, 1, 1, 1, 4'd6);
    chk("clear_prio_a", 32'(cnt_a), 32'd0);
    chk("clear_ovf_a", 32'(ovf_a), 32'd0);

    // async reset mid-operation with C at 7, flag set, prescaler at 1
    async_reset();
    step(0, 0, 0, 1, 4'd0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 4'd0);
    step(0, 0, 0, 1, 4'd7);
    step(1, 1, 0, 0, 4'd0);
    chk("pre_rst_count_c", 32'(cnt_c), 32'd7);
    chk("pre_rst_ovf_c", 32'(ovf_c), 32'd1);
    async_reset();
    step(1, 1, 0, 0, 4'd0);
    step(1, 1, 0, 0, 4'd0);
    chk("post_rst_wait_c", 32'(cnt_c), 32'd0);
    step(1, 1, 0, 0, 4'd0);
    chk("post_rst_step_c", 32'(cnt_c), 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
